// File: rtl/eq_mac_sched.sv
// eq_mac_sched: tap/band sequencer for one shared left/right MAC pair.
//
// Walks the five band filters in the order LP, B1, B2, B3, HP, issuing one
// tap per cycle with no bubbles. It then delays the issue-stage flags by
// MAC_LAT cycles, so that the accumulate controls line up with the MAC
// output stage.
//
// Ports
//   clk, rst    : rising-edge clock; synchronous active-high reset
//   start       : one-cycle pulse, a new sample pair is in the queues
//   seq_en      : queues full and valid; its fall cancels a run
//   smpl_addr   : queue read index (tap) of the issued tap
//   coeff_addr  : coefficient ROM address, band*TAPS + tap
//   band        : band being issued (0=LP .. 4=HP)
//   hf_sel      : issued tap reads the high-frequency queue (band >= 3)
//   tap_vld     : issue strobe; the four issue fields are zero while it is low
//   acc_en      : MAC accumulate enable (MAC output stage)
//   acc_clr     : load instead of add (first tap of a band)
//   res_wr      : capture the accumulator into the result register of res_band
//   res_band    : band index qualifying res_wr
//   busy        : FSM not idle
//   done        : one-cycle pulse after the fifth band result is written
//   abort       : one-cycle pulse when seq_en drops during a run
//   overrun     : sticky, a start arrived while busy and was dropped
//
// Handshake: start is accepted only in IDLE with seq_en high. A start seen
// while busy is dropped and recorded in overrun.
module eq_mac_sched #(
   parameter int TAPS    = 1021,
   parameter int MAC_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        seq_en,
   output logic [9:0]  smpl_addr,
   output logic [12:0] coeff_addr,
   output logic [2:0]  band,
   output logic        hf_sel,
   output logic        tap_vld,
   output logic        acc_en,
   output logic        acc_clr,
   output logic        res_wr,
   output logic [2:0]  res_band,
   output logic        busy,
   output logic        done,
   output logic        abort,
   output logic        overrun
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [9:0] TAP_LAST   = 10'(TAPS - 1);
   localparam logic [2:0] BAND_LAST  = 3'd4;
   localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT);

   logic [1:0]  state;
   logic [9:0]  tap_idx;
   logic [2:0]  band_idx;
   logic [12:0] coeff_base;
   logic [2:0]  drain_cnt;

   logic [MAC_LAT-1:0] p_vld;
   logic [MAC_LAT-1:0] p_first;
   logic [MAC_LAT-1:0] p_last;
   logic [2:0]         p_band [MAC_LAT];

   logic issue;
   logic issue_first;
   logic issue_last;
   logic flush;

   assign issue       = (state == S_RUN);
   assign issue_first = (tap_idx == 10'd0);
   assign issue_last  = (tap_idx == TAP_LAST);
   // Losing seq_en mid-run cancels everything still in flight.
   assign flush       = ((state == S_RUN) || (state == S_DRAIN)) && !seq_en;

   // Issue-stage outputs are forced to zero outside RUN.
   assign tap_vld    = issue;
   assign smpl_addr  = issue ? tap_idx : 10'd0;
   assign coeff_addr = issue ? coeff_base : 13'd0;
   assign band       = issue ? band_idx : 3'd0;
   assign hf_sel     = issue && (band_idx >= 3'd3);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign acc_en     = p_vld[MAC_LAT-1];
   assign acc_clr    = p_vld[MAC_LAT-1] & p_first[MAC_LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tap_idx    <= 10'd0;
         band_idx   <= 3'd0;
         coeff_base <= 13'd0;
         drain_cnt  <= 3'd0;
         abort      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         abort <= 1'b0;
         if (start && busy) overrun <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start && seq_en) begin
                  state      <= S_RUN;
                  tap_idx    <= 10'd0;
                  band_idx   <= 3'd0;
                  coeff_base <= 13'd0;
               end
            end
            S_RUN: begin
               if (!seq_en) begin
                  state <= S_IDLE;
                  abort <= 1'b1;
               end else begin
                  // Bands are laid out back to back in the ROM, so the address
                  // band*TAPS + tap is a plain running count.
                  coeff_base <= coeff_base + 13'd1;
                  if (issue_last) begin
                     tap_idx  <= 10'd0;
                     band_idx <= band_idx + 3'd1;
                     if (band_idx == BAND_LAST) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 3'd0;
                     end
                  end else begin
                     tap_idx <= tap_idx + 10'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (!seq_en) begin
                  state <= S_IDLE;
                  abort <= 1'b1;
               end else if (drain_cnt == DRAIN_LAST) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // MAC_LAT-deep flag pipeline. Stage MAC_LAT-1 is the MAC output stage.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         p_vld    <= '0;
         p_first  <= '0;
         p_last   <= '0;
         for (int i = 0; i < MAC_LAT; i++) p_band[i] <= 3'd0;
         res_wr   <= 1'b0;
         res_band <= 3'd0;
      end else begin
         p_vld[0]   <= issue;
         p_first[0] <= issue & issue_first;
         p_last[0]  <= issue & issue_last;
         p_band[0]  <= issue ? band_idx : 3'd0;
         for (int i = 1; i < MAC_LAT; i++) begin
            p_vld[i]   <= p_vld[i-1];
            p_first[i] <= p_first[i-1];
            p_last[i]  <= p_last[i-1];
            p_band[i]  <= p_band[i-1];
         end
         // The result is captured one cycle after the last tap has been added.
         res_wr   <= p_vld[MAC_LAT-1] & p_last[MAC_LAT-1];
         res_band <= (p_vld[MAC_LAT-1] & p_last[MAC_LAT-1]) ? p_band[MAC_LAT-1] : 3'd0;
      end
   end

endmodule

// File: tb/tb_eq_mac_sched.sv
// tb_eq_mac_sched: directed bench for eq_mac_sched with TAPS=4, MAC_LAT=2.
// Cycle k is the cycle that starts 1 ns after a rising edge. Inputs are driven
// for cycle k and outputs are checked in that same cycle, with k=0 being the
// start pulse cycle.
module tb_eq_mac_sched;

   localparam int TAPS    = 4;
   localparam int MAC_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        seq_en;
   logic [9:0]  smpl_addr;
   logic [12:0] coeff_addr;
   logic [2:0]  band;
   logic        hf_sel;
   logic        tap_vld;
   logic        acc_en;
   logic        acc_clr;
   logic        res_wr;
   logic [2:0]  res_band;
   logic        busy;
   logic        done;
   logic        abort;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   eq_mac_sched #(.TAPS(TAPS), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .seq_en(seq_en),
      .smpl_addr(smpl_addr), .coeff_addr(coeff_addr), .band(band),
      .hf_sel(hf_sel), .tap_vld(tap_vld), .acc_en(acc_en), .acc_clr(acc_clr),
      .res_wr(res_wr), .res_band(res_band), .busy(busy), .done(done),
      .abort(abort), .overrun(overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] all_out();
      return {26'd0, smpl_addr, coeff_addr, band, hf_sel, tap_vld, acc_en,
              acc_clr, res_wr, res_band, busy, done, abort, overrun};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs of a nominal run, k cycles after the accepted start.
   task automatic chk_nom(input int k, input logic ovr);
      logic v;
      logic wr;
      int   i;
      v  = (k >= 1) && (k <= 20);
      i  = v ? k - 1 : 0;
      wr = (k >= 7) && (k <= 23) && ((k - 7) % 4 == 0);
      chk($sformatf("tap_vld k=%0d", k),    tap_vld,    v);
      chk($sformatf("smpl_addr k=%0d", k),  smpl_addr,  v ? i % 4 : 0);
      chk($sformatf("coeff_addr k=%0d", k), coeff_addr, v ? i : 0);
      chk($sformatf("band k=%0d", k),       band,       v ? i / 4 : 0);
      chk($sformatf("hf_sel k=%0d", k),     hf_sel,     v && (k >= 13));
      chk($sformatf("acc_en k=%0d", k),     acc_en,     (k >= 3) && (k <= 22));
      chk($sformatf("acc_clr k=%0d", k),    acc_clr,
          (k >= 3) && (k <= 19) && ((k - 3) % 4 == 0));
      chk($sformatf("res_wr k=%0d", k),     res_wr,     wr);
      chk($sformatf("res_band k=%0d", k),   res_band,   wr ? (k - 7) / 4 : 0);
      chk($sformatf("done k=%0d", k),       done,       k == 24);
      chk($sformatf("busy k=%0d", k),       busy,       (k >= 1) && (k <= 24));
      chk($sformatf("abort k=%0d", k),      abort,      1'b0);
      chk($sformatf("overrun k=%0d", k),    overrun,    ovr);
   endtask

   // Nominal run covering k=0..24; a second start is raised at k=ovr_at (if >= 0).
   task automatic run_nom(input int ovr_at);
      for (int k = 0; k <= 24; k++) begin
         start = (k == 0) || (k == ovr_at);
         chk_nom(k, (ovr_at >= 0) && (k > ovr_at));
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      // clock/reset
      rst = 1'b1; start = 1'b0; seq_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_outputs", all_out(), 64'd0);

      // gating: start without seq_en is ignored
      seq_en = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk($sformatf("gate_busy k=%0d", k), busy, 1'b0);
         chk($sformatf("gate_overrun k=%0d", k), overrun, 1'b0);
         tick();
      end
      seq_en = 1'b1;

      // nominal run, then a back-to-back start at k=25
      run_nom(-1);
      run_nom(-1);

      // overrun: second start at k=10 is dropped
      run_nom(10);
      for (int k = 25; k <= 29; k++) begin
         chk($sformatf("ovr_busy k=%0d", k), busy, 1'b0);
         chk($sformatf("ovr_tap_vld k=%0d", k), tap_vld, 1'b0);
         chk($sformatf("ovr_sticky k=%0d", k), overrun, 1'b1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("reset_clears_overrun", all_out(), 64'd0);

      // abort: seq_en falls at k=9
      for (int k = 0; k <= 30; k++) begin
         start  = (k == 0);
         seq_en = (k < 9);
         if (k <= 9) chk_nom(k, 1'b0);
         else begin
            chk($sformatf("abort k=%0d", k), abort, k == 10);
            chk($sformatf("abort_busy k=%0d", k), busy, 1'b0);
            chk($sformatf("abort_done k=%0d", k), done, 1'b0);
            chk($sformatf("abort_acc_en k=%0d", k), acc_en, 1'b0);
            chk($sformatf("abort_tap_vld k=%0d", k), tap_vld, 1'b0);
            if (k >= 12) chk($sformatf("abort_res_wr k=%0d", k), res_wr, 1'b0);
            chk($sformatf("abort_overrun k=%0d", k), overrun, 1'b0);
         end
         tick();
      end
      start = 1'b0; seq_en = 1'b1;

      // reset mid-run at k=15, fresh start at k=18
      for (int k = 0; k <= 17; k++) begin
         start = (k == 0);
         rst   = (k == 15);
         if (k <= 15) chk_nom(k, 1'b0);
         else chk($sformatf("midrst_outputs k=%0d", k), all_out(), 64'd0);
         tick();
      end
      rst = 1'b0;
      run_nom(-1);

      // start during DONE (k=24) is dropped and flagged
      run_nom(24);
      chk("done_start_busy", busy, 1'b0);
      chk("done_start_overrun", overrun, 1'b1);
      tick();
      chk("done_start_no_run", tap_vld, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
